// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the divider arbiter slice.
package div_arb_pkg;

  localparam int TAMANYO   = 32;
  localparam int N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after ptr, wrapping around.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one signed divider among N_REQ requesters.
// Optional: DIV_ARB_ZERO_CHECK_EN answers Den==0 locally.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int tamanyo = TAMANYO,
  parameter int N_REQ   = N_REQ_DEF
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*tamanyo-1:0]   Num,
  input  logic [N_REQ*tamanyo-1:0]   Den,
  output logic [N_REQ-1:0]           Gnt,
  output logic                       Div_Start,
  output logic [tamanyo-1:0]         Div_Num,
  output logic [tamanyo-1:0]         Div_Den,
  input  logic [tamanyo-1:0]         Div_Coc,
  input  logic [tamanyo-1:0]         Div_Res,
  input  logic                       Div_Done,
  output logic                       Valid,
  output logic [$clog2(N_REQ)-1:0]   Id,
  output logic [tamanyo-1:0]         Coc,
  output logic [tamanyo-1:0]         Res,
  output logic                       Err
);

  localparam int IW = $clog2(N_REQ);

  state_t state, nxt;

  logic [N_REQ-1:0]   pick;
  logic [IW-1:0]      pick_idx;
  logic               any;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      win;
  logic [tamanyo-1:0] pick_num;
  logic [tamanyo-1:0] pick_den;
  logic               go_zero;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_rr (
    .req(Req),
    .ptr(ptr),
    .gnt(pick),
    .idx(pick_idx),
    .any(any)
  );

  always_comb begin
    pick_num = '0;
    pick_den = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_num = Num[i*tamanyo +: tamanyo];
        pick_den = Den[i*tamanyo +: tamanyo];
      end
    end
  end

`ifdef DIV_ARB_ZERO_CHECK_EN
  assign go_zero = (pick_den == '0);
`else
  assign go_zero = 1'b0;
  assign Err     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (any) nxt = go_zero ? RESP : ISSUE;
      ISSUE: nxt = WAIT;
      WAIT:  if (Div_Done) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      Gnt       <= '0;
      Div_Start <= 1'b0;
      Div_Num   <= '0;
      Div_Den   <= '0;
      Valid     <= 1'b0;
      Id        <= '0;
      Coc       <= '0;
      Res       <= '0;
      win       <= '0;
      ptr       <= '0;
`ifdef DIV_ARB_ZERO_CHECK_EN
      Err       <= 1'b0;
`endif
    end else begin
      Gnt       <= '0;
      Div_Start <= 1'b0;
      Valid     <= 1'b0;
      unique case (state)
        IDLE: if (any) begin
          Gnt     <= pick;
          win     <= pick_idx;
          Div_Num <= pick_num;
          Div_Den <= pick_den;
`ifdef DIV_ARB_ZERO_CHECK_EN
          if (go_zero) begin
            Coc <= '1;
            Res <= pick_num;
            Err <= 1'b1;
          end
`endif
        end
        ISSUE: Div_Start <= 1'b1;
        WAIT: if (Div_Done) begin
          Coc <= Div_Coc;
          Res <= Div_Res;
`ifdef DIV_ARB_ZERO_CHECK_EN
          Err <= 1'b0;
`endif
        end
        RESP: begin
          Valid <= 1'b1;
          Id    <= win;
          // Fairness: next search starts just past the owner.
          ptr   <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed + random bench for div_arbiter with a
// behavioural divider and round-robin reference model.
module tb_div_arbiter;

  localparam int W = 32;
  localparam int N = 4;
`ifdef DIV_ARB_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RSTa;
  logic [N-1:0]   Req;
  logic [N*W-1:0] Num, Den;
  logic [N-1:0]   Gnt;
  logic           Div_Start;
  logic [W-1:0]   Div_Num, Div_Den;
  logic [W-1:0]   Div_Coc, Div_Res;
  logic           Div_Done;
  logic           Valid;
  logic [1:0]     Id;
  logic [W-1:0]   Coc, Res;
  logic           Err;

  div_arbiter #(.tamanyo(W), .N_REQ(N)) dut (
    .CLK(CLK), .RSTa(RSTa), .Req(Req),
    .Num(Num), .Den(Den), .Gnt(Gnt),
    .Div_Start(Div_Start),
    .Div_Num(Div_Num), .Div_Den(Div_Den),
    .Div_Coc(Div_Coc), .Div_Res(Div_Res),
    .Div_Done(Div_Done), .Valid(Valid),
    .Id(Id), .Coc(Coc), .Res(Res), .Err(Err)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int div_lat  = 0;
  int cnt      = -1;
  bit spur     = 1'b0;
  logic [W-1:0] cap_n, cap_d;
  logic [W-1:0] last_coc, last_res;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(
      input logic [W-1:0] n, input logic [W-1:0] d);
    int a, b, q, r;
    if (d == '0) return {32'hFFFF_FFFF, n};
    a = int'(n);
    b = int'(d);
    q = a / b;
    r = a % b;
    return {32'(q), 32'(r)};
  endfunction

  // Winner = requester at smallest circular distance from ptr.
  function automatic int rr_pick(input logic [N-1:0] r,
                                 input int p);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      d = (i - p + N) % N;
      if (r[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic set_op(input int i, input int n, input int d);
    Num[i*W +: W] = W'(n);
    Den[i*W +: W] = W'(d);
  endtask

  task automatic rand_op(input int i);
    int mag;
    mag = int'($urandom_range(2, 500));
    if ($urandom_range(0, 1) == 1) mag = -mag;
    set_op(i, int'($urandom), mag);
  endtask

  initial begin
    Div_Done = 1'b0;
    Div_Coc  = '0;
    Div_Res  = '0;
    forever begin
      @(negedge CLK);
      Div_Done = 1'b0;
      if (!RSTa) cnt = -1;
      else begin
        if (Div_Start) begin
          cap_n = Div_Num;
          cap_d = Div_Den;
          cnt   = div_lat;
        end
        if (cnt == 0) begin
          {Div_Coc, Div_Res} = ref_div(cap_n, cap_d);
          Div_Done = 1'b1;
          cnt = -1;
        end else if (cnt > 0) cnt--;
        if (spur) begin
          Div_Done = 1'b1;
          Div_Coc  = 32'h5A5A_0001;
          Div_Res  = 32'h0BAD_0002;
        end
      end
    end
  end

  // Caller sets Req at a negedge; returns at the Valid negedge.
  task automatic do_op(input bit hold, input int lat,
                       output int w);
    int ew, vc, ns, sc;
    logic [W-1:0] en, ed;
    logic [63:0] qr;
    logic [N-1:0] g1;
    bit zp, got;
    ew = rr_pick(Req, ptr_m);
    en = Num[ew*W +: W];
    ed = Den[ew*W +: W];
    zp = ZC && (ed == '0);
    qr = zp ? {32'hFFFF_FFFF, en} : ref_div(en, ed);
    div_lat = lat;
    w   = -1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge CLK);
      if (Gnt != '0) got = 1'b1;
    end
    chk("gnt_seen", 64'(got), 64'd1);
    if (!got) return;
    w = oh_idx(Gnt);
    chk("gnt", 64'(Gnt), 64'(1 << ew));
    if (!hold) Req = '0;
    vc = 0; ns = 0; sc = 0;
    g1 = '0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge CLK);
      if (k == 1) g1 = Gnt;
      if (Div_Start) begin
        ns++;
        sc = k;
        chk("div_num", 64'(Div_Num), 64'(en));
        chk("div_den", 64'(Div_Den), 64'(ed));
      end
      if (Valid) begin
        got = 1'b1;
        vc  = k;
      end
    end
    chk("gnt_pulse", 64'(g1), 64'd0);
    chk("valid_seen", 64'(got), 64'd1);
    chk("n_start", 64'(ns), zp ? 64'd0 : 64'd1);
    if (!zp) chk("start_cyc", 64'(sc), 64'd1);
    chk("latency", 64'(vc), zp ? 64'd1 : 64'(lat + 3));
    chk("id", 64'(Id), 64'(w));
    chk("coc", 64'(Coc), 64'(qr[63:32]));
    chk("res", 64'(Res), 64'(qr[31:0]));
    chk("err", 64'(Err), 64'(zp));
    last_coc = qr[63:32];
    last_res = qr[31:0];
    ptr_m = (ew + 1) % N;
  endtask

  initial begin
    int w, nv;
    int ord[5];
    bit got;
    ord = '{0, 1, 2, 3, 0};
    Req  = '0;
    Num  = '0;
    Den  = '0;
    RSTa = 1'b1;
    #2 RSTa = 1'b0;
    #1;
    chk("rst_gnt",   64'(Gnt),       64'd0);
    chk("rst_start", 64'(Div_Start), 64'd0);
    chk("rst_valid", 64'(Valid),     64'd0);
    chk("rst_err",   64'(Err),       64'd0);
    chk("rst_id",    64'(Id),        64'd0);
    chk("rst_coc",   64'(Coc),       64'd0);
    chk("rst_res",   64'(Res),       64'd0);
    chk("rst_dnum",  64'(Div_Num),   64'd0);
    chk("rst_dden",  64'(Div_Den),   64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RSTa = 1'b1;

    set_op(0, 11, 3);
    set_op(1, -20, 6);
    set_op(2, 50, -8);
    set_op(3, 9, 9);
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_op(1'b1, k % 3, w);
      chk("rr_order", 64'(w), 64'(ord[k]));
    end
    Req = '0;

    set_op(0, 100, 7);
    Req = 4'b0001;
    do_op(1'b0, 2, w);
    chk("d_coc_14", 64'(Coc), 64'd14);
    chk("d_res_2",  64'(Res), 64'd2);
    chk("d_id_0",   64'(Id),  64'd0);

    set_op(2, -7, 2);
    Req = 4'b0100;
    do_op(1'b0, 0, w);
    chk("n_coc_m3", 64'(Coc), 64'(32'hFFFF_FFFD));
    chk("n_res_m1", 64'(Res), 64'(32'hFFFF_FFFF));
    chk("n_id_2",   64'(Id),  64'd2);

    set_op(1, -9, 0);
    Req = 4'b0010;
    do_op(1'b0, 1, w);
    chk("z_err", 64'(Err), 64'(ZC));

    @(negedge CLK);
    spur = 1'b1;
    nv = 0;
    @(negedge CLK);
    if (Valid) nv++;
    spur = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (Valid) nv++;
    end
    chk("spur_valid", 64'(nv),  64'd0);
    chk("spur_coc",   64'(Coc), 64'(last_coc));
    chk("spur_res",   64'(Res), 64'(last_res));

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) rand_op(i);
      Req = 4'($urandom_range(1, 15));
      do_op(1'b0, int'($urandom_range(0, 4)), w);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    set_op(0, 77, 5);
    Req = 4'b0001;
    div_lat = 10;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge CLK);
      if (Gnt != '0) got = 1'b1;
    end
    chk("r_gnt_seen", 64'(got), 64'd1);
    Req = '0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge CLK);
      if (Div_Start) got = 1'b1;
    end
    chk("r_start_seen", 64'(got), 64'd1);
    @(negedge CLK);
    #2 RSTa = 1'b0;
    #1;
    chk("ar_gnt",   64'(Gnt),       64'd0);
    chk("ar_start", 64'(Div_Start), 64'd0);
    chk("ar_valid", 64'(Valid),     64'd0);
    chk("ar_err",   64'(Err),       64'd0);
    chk("ar_id",    64'(Id),        64'd0);
    chk("ar_coc",   64'(Coc),       64'd0);
    chk("ar_res",   64'(Res),       64'd0);
    chk("ar_dnum",  64'(Div_Num),   64'd0);
    chk("ar_dden",  64'(Div_Den),   64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RSTa  = 1'b1;
    ptr_m = 0;
    nv = 0;
    repeat (15) begin
      @(negedge CLK);
      if (Valid) nv++;
    end
    chk("ar_no_valid", 64'(nv), 64'd0);
    set_op(2, 1000, -33);
    Req = 4'b0100;
    do_op(1'b0, 1, w);
    chk("ar_first", 64'(w), 64'd2);

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
